// File: rtl/sram_2p_lanes.sv
// Simple dual-port lane-masked RAM with 1- or 2-cycle read latency and selectable RDW mode.
// Define SRAM_CLEAR_EN to add a zero-clear sweep after reset and on clear_i.
module sram_2p_lanes #(
    parameter int unsigned AddrWidth   = 10,
    parameter int unsigned DataWidth   = 9,
    parameter int unsigned NumLanes    = 2,
    parameter int unsigned ReadLatency = 1,
    parameter string       RdwMode     = "read_first"
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumLanes-1:0]           wen_i,
    input  logic [AddrWidth-1:0]          waddr_i,
    input  logic [NumLanes*DataWidth-1:0] wdata_i,
    input  logic                          ren_i,
    input  logic [AddrWidth-1:0]          raddr_i,
    output logic [NumLanes*DataWidth-1:0] rdata_o,
    output logic                          rvalid_o,
    input  logic                          clear_i,
    output logic                          busy_o
);
    localparam int unsigned W     = NumLanes * DataWidth;
    localparam int unsigned Depth = 2 ** AddrWidth;
    localparam bit WriteFirst     = (RdwMode == "write_first");

    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $error("sram_2p_lanes: ReadLatency must be 1 or 2");
    end
    if (NumLanes < 1) begin : g_bad_lanes
        $error("sram_2p_lanes: NumLanes must be at least 1");
    end
    if (RdwMode != "read_first" && RdwMode != "write_first") begin : g_bad_rdw
        $error("sram_2p_lanes: RdwMode must be read_first or write_first");
    end

    logic [W-1:0]         mem_q [Depth];
    logic                 busy;
    logic [AddrWidth-1:0] clr_addr;

`ifdef SRAM_CLEAR_EN
    typedef enum logic [0:0] {StIdle, StClear} state_e;
    state_e               state_q;
    logic [AddrWidth-1:0] cnt_q;

    // Reset lands in StClear so the array is zeroed before first use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = (state_q == StClear);
    assign clr_addr = cnt_q;
`else
    logic unused_clear;
    assign unused_clear = clear_i;
    assign busy         = 1'b0;
    assign clr_addr     = '0;
`endif

    assign busy_o = busy;

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem_q[clr_addr] <= '0;
        end else begin
            for (int l = 0; l < NumLanes; l++) begin
                if (wen_i[l]) begin
                    mem_q[waddr_i][l*DataWidth +: DataWidth] <= wdata_i[l*DataWidth +: DataWidth];
                end
            end
        end
    end

    logic         ren_ok;
    logic [W-1:0] rd_word;

    assign ren_ok = ren_i & ~busy;

    always_comb begin
        rd_word = mem_q[raddr_i];
        if (WriteFirst && !busy && (raddr_i == waddr_i)) begin
            for (int l = 0; l < NumLanes; l++) begin
                if (wen_i[l]) rd_word[l*DataWidth +: DataWidth] = wdata_i[l*DataWidth +: DataWidth];
            end
        end
    end

    logic         s1_valid_q;
    logic [W-1:0] s1_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= ren_ok;
            if (ren_ok) s1_data_q <= rd_word;
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic         s2_valid_q;
        logic [W-1:0] s2_data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_q;
            end
        end

        assign rvalid_o = s2_valid_q;
        assign rdata_o  = s2_data_q;
    end else begin : g_lat1
        assign rvalid_o = s1_valid_q;
        assign rdata_o  = s1_data_q;
    end

endmodule

// File: tb/tb_sram_2p_lanes.sv
// Bench for sram_2p_lanes: two instances (latency 1 read_first, latency 2 write_first) checked
// every cycle against an array model, plus directed literal checks. Honours SRAM_CLEAR_EN.
module tb_sram_2p_lanes;
    localparam int W     = 18;
    localparam int LW    = 9;
    localparam int Depth = 1024;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [1:0]    wen;
    logic [9:0]    waddr, raddr;
    logic [W-1:0]  wdata;
    logic          ren, clear;
    logic [W-1:0]  rdata1, rdata2;
    logic          rvalid1, rvalid2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sram_2p_lanes dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata1), .rvalid_o(rvalid1),
        .clear_i(clear), .busy_o(busy1)
    );

    sram_2p_lanes #(.ReadLatency(2), .RdwMode("write_first")) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata2), .rvalid_o(rvalid2),
        .clear_i(clear), .busy_o(busy2)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: plain word array, expected output per instance, remaining sweep cycles.
    logic [W-1:0] mm [Depth];
    logic         v1 = 0, v2 = 0, p2v = 0, rd_hit;
    logic [W-1:0] e1 = '0, e2 = '0, p2d = '0, old_w, wf_w;
    int           busy_left = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1 = 0; e1 = '0; v2 = 0; e2 = '0; p2v = 0; p2d = '0;
`ifdef SRAM_CLEAR_EN
            busy_left = Depth;
            for (int i = 0; i < Depth; i++) mm[i] = '0;
`endif
        end else begin
            v2 = p2v;
            if (p2v) e2 = p2d;
            rd_hit = 0;
            old_w  = '0;
            wf_w   = '0;
            if (busy_left == 0) begin
                if (ren) begin
                    rd_hit = 1;
                    old_w  = mm[raddr];
                    wf_w   = old_w;
                    if (raddr == waddr)
                        for (int l = 0; l < 2; l++)
                            if (wen[l]) wf_w[l*LW +: LW] = wdata[l*LW +: LW];
                end
                for (int l = 0; l < 2; l++)
                    if (wen[l]) mm[waddr][l*LW +: LW] = wdata[l*LW +: LW];
`ifdef SRAM_CLEAR_EN
                if (clear) begin
                    busy_left = Depth;
                    for (int i = 0; i < Depth; i++) mm[i] = '0;
                end
`endif
            end else begin
                busy_left--;
            end
            v1 = rd_hit;
            if (rd_hit) e1 = old_w;
            p2v = rd_hit;
            if (rd_hit) p2d = wf_w;
        end
    end

    always @(negedge clk_i) begin
        chk("m_rvalid1", W'(rvalid1), W'(v1));
        chk("m_rdata1", rdata1, e1);
        chk("m_busy1", W'(busy1), W'(busy_left > 0));
        chk("m_rvalid2", W'(rvalid2), W'(v2));
        chk("m_rdata2", rdata2, e2);
        chk("m_busy2", W'(busy2), W'(busy_left > 0));
    end

    task automatic op(input logic [1:0] we, input logic [9:0] wa, input logic [W-1:0] wd,
                      input logic re, input logic [9:0] ra);
        wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
        @(negedge clk_i);
        wen = 2'b00; ren = 1'b0;
    endtask

    // Called right after a read op: latency-1 result now, latency-2 result next cycle.
    task automatic rdchk(input string nm, input logic [W-1:0] x1, input logic [W-1:0] x2);
        chk({nm, "_rv1"}, W'(rvalid1), W'(1));
        chk({nm, "_d1"}, rdata1, x1);
        @(negedge clk_i);
        chk({nm, "_rv2"}, W'(rvalid2), W'(1));
        chk({nm, "_d2"}, rdata2, x2);
    endtask

    // Counts busy cycles; ports are driven meanwhile and must be ignored.
    task automatic wait_idle(input string nm);
        int n = 0;
        int exp_n;
`ifdef SRAM_CLEAR_EN
        exp_n = Depth;
`else
        exp_n = 0;
`endif
        while (busy1 && n < 2000) begin
            n++;
            wen = 2'b11; waddr = 10'd0; wdata = 18'h3FFFF; ren = 1'b1; raddr = 10'd0;
            @(negedge clk_i);
        end
        wen = 2'b00; ren = 1'b0;
        chk({nm, "_busy_cycles"}, W'(n), W'(exp_n));
    endtask

    initial begin
        wen = 2'b00; waddr = '0; wdata = '0; ren = 1'b0; raddr = '0; clear = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        chk("reset_rvalid1", W'(rvalid1), W'(0));
        chk("reset_rdata2", rdata2, '0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        wait_idle("init");

`ifdef SRAM_CLEAR_EN
        op(2'b00, 10'd0, '0, 1'b1, 10'd0);    rdchk("clr0", '0, '0);
        op(2'b00, 10'd0, '0, 1'b1, 10'd513);  rdchk("clr513", '0, '0);
        op(2'b00, 10'd0, '0, 1'b1, 10'd1023); rdchk("clr1023", '0, '0);
`endif

        // Full write then read back.
        op(2'b11, 10'd5, {9'h0AA, 9'h1FF}, 1'b0, '0);
        op(2'b00, '0, '0, 1'b1, 10'd5);
        rdchk("t1", 18'h155FF, 18'h155FF);

        // Lane-0 only write.
        op(2'b01, 10'd5, {9'h000, 9'h003}, 1'b0, '0);
        op(2'b00, '0, '0, 1'b1, 10'd5);
        rdchk("t2", 18'h15403, 18'h15403);

        // Same-address collisions.
        op(2'b11, 10'd7, {9'h100, 9'h100}, 1'b0, '0);
        op(2'b11, 10'd7, {9'h055, 9'h055}, 1'b1, 10'd7);
        rdchk("t3_both", 18'h20100, 18'h0AA55);
        op(2'b11, 10'd7, {9'h100, 9'h100}, 1'b0, '0);
        op(2'b10, 10'd7, {9'h055, 9'h055}, 1'b1, 10'd7);
        rdchk("t3_lane1", 18'h20100, 18'h0AB00);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) op(2'b11, 10'(i), W'(i), 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            ren = 1'b1; raddr = 10'(i);
            @(negedge clk_i);
            chk("t4_rv1", W'(rvalid1), W'(1));
            chk("t4_d1", rdata1, W'(i));
            if (i > 0) chk("t4_d2", rdata2, W'(i - 1));
        end
        ren = 1'b0;
        @(negedge clk_i);
        chk("t4_rv1_end", W'(rvalid1), W'(0));
        chk("t4_d1_hold", rdata1, W'(3));
        chk("t4_d2_last", rdata2, W'(3));

`ifdef SRAM_CLEAR_EN
        op(2'b11, 10'd9, 18'h001FF, 1'b0, '0);
        clear = 1'b1;
        @(negedge clk_i);
        clear = 1'b0;
        wait_idle("t5");
        op(2'b00, '0, '0, 1'b1, 10'd9);
        rdchk("t5_read9", '0, '0);
`endif

        // Async reset with a read in flight.
        ren = 1'b1; raddr = 10'd5;
        @(posedge clk_i);
        ren = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rv1", W'(rvalid1), W'(0));
        chk("t6_d1", rdata1, '0);
        chk("t6_rv2", W'(rvalid2), W'(0));
        chk("t6_d2", rdata2, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_idle("t6");
        op(2'b00, '0, '0, 1'b1, 10'd5);
`ifdef SRAM_CLEAR_EN
        rdchk("t6_read5", '0, '0);
`else
        rdchk("t6_read5", 18'h15403, 18'h15403);
`endif
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
